hazard_scoreboard: RTL and testbench

Parametrised data-hazard scoreboard for the ID stage of the in-order pipeline. It tracks destination registers of instructions in flight over `DEPTH` post-ID stages in an internal shift register, instead of taking per-stage destinations as inputs. It raises a stall request for true read-after-write conflicts, with forwarding on or off, and with a configurable load-use window. With forwarding on, it selects the forwarding source stage for each operand and counts inserted bubbles.

---
 rtl/hazard_pkg.sv | 32 +++
 rtl/hazard_entry_cmp.sv | 23 ++
 rtl/hazard_scoreboard.sv | 93 +++++++++
 tb/tb_hazard_scoreboard.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types for the ID-stage hazard scoreboard: the in-flight entry
// record, the register-file forwarding code and the empty-slot constant.
package hazard_pkg;

    // Entries reserve room for the widest supported register index; narrower
    // indices are zero-extended so comparisons stay exact.
    localparam int DEST_W = 8;
    localparam int FWD_RF = 0;

    typedef struct packed {
        logic              valid;
        logic [DEST_W-1:0] dest;
        logic              wb_en;
        logic              mem_r_en;
    } hazard_entry_t;

    localparam hazard_entry_t BUBBLE = '0;

    function automatic hazard_entry_t make_entry(
        input logic [DEST_W-1:0] dest,
        input logic              wb_en,
        input logic              mem_r_en
    );
        hazard_entry_t e;
        e.valid    = 1'b1;
        e.dest     = dest;
        e.wb_en    = wb_en;
        e.mem_r_en = mem_r_en;
        return e;
    endfunction

endpackage

// File: rtl/hazard_entry_cmp.sv
// Compares one in-flight entry against both ID source operands.
module hazard_entry_cmp
    import hazard_pkg::*;
#(
    parameter int REG_AW = 4
) (
    input  hazard_entry_t     entry,
    input  logic [REG_AW-1:0] src1,
    input  logic [REG_AW-1:0] src2,
    input  logic              two_src,
    output logic              m1,
    output logic              m2,
    output logic              is_load
);

    logic writes;

    assign writes  = entry.valid & entry.wb_en;
    assign m1      = writes & (entry.dest == DEST_W'(src1));
    assign m2      = writes & (entry.dest == DEST_W'(src2)) & two_src;
    assign is_load = entry.valid & entry.mem_r_en;

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage RAW hazard scoreboard: tracks in-flight destinations in a shift
// register, requests stalls and picks forwarding sources per operand.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int REG_AW   = 4,
    parameter int DEPTH    = 2,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16,
    parameter int SEL_W    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              forward_en,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] src1,
    input  logic [REG_AW-1:0] src2,
    input  logic              two_src,
    input  logic [REG_AW-1:0] id_dest,
    input  logic              id_wb_en,
    input  logic              id_mem_r_en,
    input  logic              freeze,
    input  logic              flush,
    output logic              hazard_detected,
    output logic [SEL_W-1:0]  fwd_sel1,
    output logic [SEL_W-1:0]  fwd_sel2,
    output logic [CNT_W-1:0]  stall_count
);

    hazard_entry_t entries [DEPTH];
    logic          m1      [DEPTH];
    logic          m2      [DEPTH];
    logic          is_load [DEPTH];

    logic any_hit;
    logic load_hit;
    logic issue;

    for (genvar g = 0; g < DEPTH; g++) begin : g_cmp
        hazard_entry_cmp #(.REG_AW(REG_AW)) u_cmp (
            .entry   (entries[g]),
            .src1    (src1),
            .src2    (src2),
            .two_src (two_src),
            .m1      (m1[g]),
            .m2      (m2[g]),
            .is_load (is_load[g])
        );
    end

    always_comb begin
        any_hit  = 1'b0;
        load_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            any_hit = any_hit | m1[i] | m2[i];
            if (i < LOAD_LAT) begin
                load_hit = load_hit | ((m1[i] | m2[i]) & is_load[i]);
            end
        end
        hazard_detected = id_valid & (forward_en ? load_hit : any_hit);
    end

    // Scan oldest to youngest so the youngest producer overwrites older ones.
    always_comb begin
        fwd_sel1 = SEL_W'(FWD_RF);
        fwd_sel2 = SEL_W'(FWD_RF);
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (m1[i]) fwd_sel1 = SEL_W'(i + 1);
            if (m2[i]) fwd_sel2 = SEL_W'(i + 1);
        end
        if (!forward_en || !id_valid || hazard_detected) begin
            fwd_sel1 = SEL_W'(FWD_RF);
            fwd_sel2 = SEL_W'(FWD_RF);
        end
    end

    assign issue = id_valid & ~hazard_detected & ~flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) entries[i] <= BUBBLE;
            stall_count <= '0;
        end else if (!freeze) begin
            for (int i = 1; i < DEPTH; i++) entries[i] <= entries[i-1];
            entries[0] <= issue ? make_entry(DEST_W'(id_dest), id_wb_en, id_mem_r_en)
                                : BUBBLE;
            if (hazard_detected && !flush && stall_count != {CNT_W{1'b1}}) begin
                stall_count <= stall_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed self-checking bench for hazard_scoreboard: a default instance,
// a 2-bit counter instance and a DEPTH=3 / LOAD_LAT=2 instance share stimulus.
module tb_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       rst;
    logic       forward_en, id_valid, two_src, id_wb_en, id_mem_r_en, freeze, flush;
    logic [3:0] src1, src2, id_dest;

    logic        hz_a, hz_b, hz_c;
    logic [1:0]  sel1_a, sel2_a, sel1_b, sel2_b, sel1_c, sel2_c;
    logic [15:0] cnt_a, cnt_c;
    logic [1:0]  cnt_b;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    hazard_scoreboard u_a (
        .clk(clk), .rst(rst), .forward_en(forward_en), .id_valid(id_valid),
        .src1(src1), .src2(src2), .two_src(two_src), .id_dest(id_dest),
        .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en), .freeze(freeze), .flush(flush),
        .hazard_detected(hz_a), .fwd_sel1(sel1_a), .fwd_sel2(sel2_a), .stall_count(cnt_a)
    );

    hazard_scoreboard #(.CNT_W(2)) u_b (
        .clk(clk), .rst(rst), .forward_en(forward_en), .id_valid(id_valid),
        .src1(src1), .src2(src2), .two_src(two_src), .id_dest(id_dest),
        .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en), .freeze(freeze), .flush(flush),
        .hazard_detected(hz_b), .fwd_sel1(sel1_b), .fwd_sel2(sel2_b), .stall_count(cnt_b)
    );

    hazard_scoreboard #(.DEPTH(3), .LOAD_LAT(2)) u_c (
        .clk(clk), .rst(rst), .forward_en(forward_en), .id_valid(id_valid),
        .src1(src1), .src2(src2), .two_src(two_src), .id_dest(id_dest),
        .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en), .freeze(freeze), .flush(flush),
        .hazard_detected(hz_c), .fwd_sel1(sel1_c), .fwd_sel2(sel2_c), .stall_count(cnt_c)
    );

    task automatic checkOutput(input string tag, input int actual, input int expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Inputs change 1 time unit after a rising edge; outputs settle before checks.
    task automatic applyStimulus(
        input logic fe, input logic v, input logic [3:0] s1, input logic [3:0] s2,
        input logic ts, input logic [3:0] d, input logic wb, input logic ld,
        input logic fz, input logic fl
    );
        forward_en = fe; id_valid = v; src1 = s1; src2 = s2; two_src = ts;
        id_dest = d; id_wb_en = wb; id_mem_r_en = ld; freeze = fz; flush = fl;
        #2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        // Reset state, with a matching source presented while rst is high
        applyStimulus(1'b0, 1'b1, 4'd0, 4'd0, 1'b1, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("reset_hazard", hz_a, 0);
        checkOutput("reset_sel1", sel1_a, 0);
        checkOutput("reset_count", cnt_a, 0);
        rst = 1'b0;

        // Load-use with forwarding
        applyStimulus(1'b1, 1'b1, 4'd0, 4'd0, 1'b0, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("lu_issue_hazard", hz_a, 0);
        tick();
        applyStimulus(1'b1, 1'b1, 4'd3, 4'd0, 1'b0, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("lu_stall_hazard", hz_a, 1);
        checkOutput("lu_stall_sel1", sel1_a, 0);
        tick();
        applyStimulus(1'b1, 1'b1, 4'd3, 4'd0, 1'b0, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("lu_after_hazard", hz_a, 0);
        checkOutput("lu_after_sel1", sel1_a, 2);
        checkOutput("lu_after_count", cnt_a, 1);

        // Reset mid-stall, with freeze and flush also high
        tick();
        applyStimulus(1'b1, 1'b1, 4'd0, 4'd0, 1'b0, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 1'b1, 4'd3, 4'd0, 1'b0, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("rstmid_pre_hazard", hz_a, 1);
        rst = 1'b1;
        applyStimulus(1'b1, 1'b1, 4'd3, 4'd0, 1'b0, 4'd4, 1'b1, 1'b0, 1'b1, 1'b1);
        tick();
        rst = 1'b0;
        applyStimulus(1'b1, 1'b1, 4'd3, 4'd0, 1'b0, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("rstmid_hazard", hz_a, 0);
        checkOutput("rstmid_sel1", sel1_a, 0);
        checkOutput("rstmid_count", cnt_a, 0);

        // Stall-only dependency through src2
        doReset();
        applyStimulus(1'b0, 1'b1, 4'd0, 4'd0, 1'b0, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        for (int k = 0; k < 2; k++) begin
            applyStimulus(1'b0, 1'b1, 4'd1, 4'd5, 1'b1, 4'd6, 1'b1, 1'b0, 1'b0, 1'b0);
            checkOutput($sformatf("so_stall%0d_hazard", k), hz_a, 1);
            checkOutput($sformatf("so_stall%0d_sel2", k), sel2_a, 0);
            tick();
        end
        applyStimulus(1'b0, 1'b1, 4'd1, 4'd5, 1'b1, 4'd6, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("so_after_hazard", hz_a, 0);
        checkOutput("so_after_sel2", sel2_a, 0);
        checkOutput("so_after_count", cnt_a, 2);

        // Same dependency with src2 unused, then forwarding toggled on
        doReset();
        applyStimulus(1'b0, 1'b1, 4'd0, 4'd0, 1'b0, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b1, 4'd1, 4'd5, 1'b0, 4'd6, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("so_nosrc2_hazard", hz_a, 0);
        applyStimulus(1'b1, 1'b1, 4'd1, 4'd5, 1'b1, 4'd6, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("fe_toggle_hazard", hz_a, 0);
        checkOutput("fe_toggle_sel2", sel2_a, 1);

        // Youngest producer wins
        doReset();
        applyStimulus(1'b1, 1'b1, 4'd0, 4'd0, 1'b0, 4'd7, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 1'b1, 4'd0, 4'd0, 1'b0, 4'd7, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 1'b1, 4'd7, 4'd7, 1'b1, 4'd8, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("young_hazard", hz_a, 0);
        checkOutput("young_sel1", sel1_a, 1);
        checkOutput("young_sel2", sel2_a, 1);
        applyStimulus(1'b1, 1'b0, 4'd7, 4'd7, 1'b1, 4'd8, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("novalid_sel1", sel1_a, 0);
        checkOutput("novalid_hazard", hz_a, 0);

        // Freeze during a load-use hazard
        doReset();
        applyStimulus(1'b1, 1'b1, 4'd0, 4'd0, 1'b0, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, 1'b1, 4'd3, 4'd0, 1'b0, 4'd4, 1'b1, 1'b0, 1'b1, 1'b0);
            checkOutput($sformatf("frz%0d_hazard", k), hz_a, 1);
            checkOutput($sformatf("frz%0d_count", k), cnt_a, 0);
            tick();
        end
        applyStimulus(1'b1, 1'b1, 4'd3, 4'd0, 1'b0, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("frz_release_hazard", hz_a, 1);
        tick();
        applyStimulus(1'b1, 1'b1, 4'd3, 4'd0, 1'b0, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("frz_after_hazard", hz_a, 0);
        checkOutput("frz_after_sel1", sel1_a, 2);
        checkOutput("frz_after_count", cnt_a, 1);

        // Flush coinciding with a load-use hazard
        doReset();
        applyStimulus(1'b1, 1'b1, 4'd0, 4'd0, 1'b0, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 1'b1, 4'd3, 4'd0, 1'b0, 4'd4, 1'b1, 1'b0, 1'b0, 1'b1);
        checkOutput("flush_hazard", hz_a, 1);
        tick();
        applyStimulus(1'b1, 1'b1, 4'd3, 4'd0, 1'b0, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("flush_next_hazard", hz_a, 0);
        checkOutput("flush_count", cnt_a, 0);

        // Register index 0 is tracked like any other
        doReset();
        applyStimulus(1'b1, 1'b1, 4'd9, 4'd0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 1'b1, 4'd0, 4'd0, 1'b0, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("r0_hazard", hz_a, 1);

        // Five load-use stalls: 16-bit counter reaches 5, 2-bit counter saturates
        doReset();
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b1, 1'b1, 4'd0, 4'd0, 1'b0, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0);
            tick();
            applyStimulus(1'b1, 1'b1, 4'd3, 4'd0, 1'b0, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0);
            tick();
        end
        checkOutput("sat_count_wide", cnt_a, 5);
        checkOutput("sat_count_narrow", cnt_b, 3);

        // DEPTH=3, LOAD_LAT=2: two stall cycles then forward from entry 2
        doReset();
        applyStimulus(1'b1, 1'b1, 4'd0, 4'd0, 1'b0, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        for (int k = 0; k < 2; k++) begin
            applyStimulus(1'b1, 1'b1, 4'd3, 4'd0, 1'b0, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0);
            checkOutput($sformatf("win_stall%0d_hazard", k), hz_c, 1);
            tick();
        end
        applyStimulus(1'b1, 1'b1, 4'd3, 4'd0, 1'b0, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("win_after_hazard", hz_c, 0);
        checkOutput("win_after_sel1", sel1_c, 3);
        checkOutput("win_after_count", cnt_c, 2);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
